// File: rtl/pipelined_bls_subtractor.sv
// WIDTH-bit borrow-lookahead subtractor (Diff = X - Y - Bin). Each pipeline stage resolves one GROUP-bit
// slice, and the borrow is registered between slices. Valid/ready handshakes sit on both sides.
module pipelined_bls_subtractor #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero,
    output logic             Neg,
    output logic             Ovf
);
    localparam int NG = WIDTH / GROUP;

    // Every borrow is a flat sum of generate/propagate products, so no ripple path exists inside a slice.
    function automatic logic [GROUP:0] slice_borrows(input logic [GROUP-1:0] x,
                                                     input logic [GROUP-1:0] y,
                                                     input logic             b_in);
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   b;
        logic             term;
        g    = ~x & y;
        p    = ~(x ^ y);
        b    = '0;
        b[0] = b_in;
        for (int i = 0; i < GROUP; i++) begin
            term = b_in;
            for (int k = 0; k <= i; k++) term = term & p[k];
            b[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                b[i+1] = b[i+1] | term;
            end
        end
        return b;
    endfunction

    // Stage registers. Each stage carries the full operand words forward. Only the slices
    // that later stages have not yet used are live.
    logic             s_v [NG];
    logic [WIDTH-1:0] s_x [NG];
    logic [WIDTH-1:0] s_y [NG];
    logic [WIDTH-1:0] s_d [NG];
    logic             s_b [NG];
    logic             started;
    logic             zero_q, neg_q, ovf_q;

    // Stage inputs and computed next values
    logic             cur_v [NG];
    logic [WIDTH-1:0] cur_x [NG];
    logic [WIDTH-1:0] cur_y [NG];
    logic [WIDTH-1:0] cur_d [NG];
    logic             cur_b [NG];
    logic [GROUP-1:0] xs    [NG];
    logic [GROUP-1:0] ys    [NG];
    logic [GROUP:0]   brw   [NG];
    logic [WIDTH-1:0] nxt_d [NG];
    logic             nxt_b [NG];
    logic             zero_n, neg_n, ovf_n;
    logic             adv;

    assign adv       = ~s_v[NG-1] | out_ready;
    assign in_ready  = adv & started;
    assign out_valid = s_v[NG-1];
    assign Diff      = s_d[NG-1];
    assign Bout      = s_b[NG-1];
    assign Zero      = zero_q;
    assign Neg       = neg_q;
    assign Ovf       = ovf_q;

    // NOTE: every always_comb output is assigned on every path before use, so no latch is inferred.
    always_comb begin
        cur_v[0] = in_valid & in_ready;
        cur_x[0] = X;
        cur_y[0] = Y;
        cur_d[0] = '0;
        cur_b[0] = Bin;
        for (int k = 1; k < NG; k++) begin
            cur_v[k] = s_v[k-1];
            cur_x[k] = s_x[k-1];
            cur_y[k] = s_y[k-1];
            cur_d[k] = s_d[k-1];
            cur_b[k] = s_b[k-1];
        end
        for (int k = 0; k < NG; k++) begin
            xs[k]    = cur_x[k][k*GROUP +: GROUP];
            ys[k]    = cur_y[k][k*GROUP +: GROUP];
            brw[k]   = slice_borrows(xs[k], ys[k], cur_b[k]);
            nxt_d[k] = cur_d[k];
            nxt_d[k][k*GROUP +: GROUP] = xs[k] ^ ys[k] ^ brw[k][GROUP-1:0];
            nxt_b[k] = brw[k][GROUP];
        end
        zero_n = (nxt_d[NG-1] == '0);
        neg_n  = nxt_d[NG-1][WIDTH-1];
        ovf_n  = (cur_x[NG-1][WIDTH-1] != cur_y[NG-1][WIDTH-1]) &&
                 (nxt_d[NG-1][WIDTH-1] != cur_x[NG-1][WIDTH-1]);
    end

    // NOTE: sequential state uses non-blocking assignments, so every stage samples the values
    //       that its neighbour held before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data registers are reset along with the valids because Diff and the flags
            //       are visible outputs that must read 0 after reset.
            for (int k = 0; k < NG; k++) begin
                s_v[k] <= 1'b0;
                s_x[k] <= '0;
                s_y[k] <= '0;
                s_d[k] <= '0;
                s_b[k] <= 1'b0;
            end
            started <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            started <= 1'b1;
            if (adv) begin
                for (int k = 0; k < NG; k++) begin
                    s_v[k] <= cur_v[k];
                    // Bubbles leave the data untouched, so the output holds its last result.
                    if (cur_v[k]) begin
                        s_x[k] <= cur_x[k];
                        s_y[k] <= cur_y[k];
                        s_d[k] <= nxt_d[k];
                        s_b[k] <= nxt_b[k];
                    end
                end
                if (cur_v[NG-1]) begin
                    zero_q <= zero_n;
                    neg_q  <= neg_n;
                    ovf_q  <= ovf_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_bls_subtractor.sv
// Scoreboard bench for pipelined_bls_subtractor. The stimulus process pushes hand-computed results,
// and a negedge monitor pops them and compares them on every output handshake.
module tb_pipelined_bls_subtractor;
    localparam int WIDTH = 16;
    localparam int GROUP = 4;
    localparam int NG    = WIDTH / GROUP;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             zero;
        logic             neg;
        logic             ovf;
        int               acc;
        bit               chk_lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Zero;
    logic             Neg;
    logic             Ovf;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   pushed   = 0;
    int   popped   = 0;
    logic [WIDTH-1:0] held_d;

    pipelined_bls_subtractor #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout),
        .Zero      (Zero),
        .Neg       (Neg),
        .Ovf       (Ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one vector, waits for acceptance, and records its expected result.
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic b,
                        input logic [WIDTH-1:0] ed, input logic eb, input logic ez,
                        input logic en, input logic eo, input bit lat, input bit push);
        exp_t e;
        int   n;
        X = x; Y = y; Bin = b; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        if (push) begin
            e.diff = ed; e.bout = eb; e.zero = ez; e.neg = en; e.ovf = eo;
            e.acc = cyc; e.chk_lat = lat;
            sb_q.push_back(e);
            pushed++;
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check("drain_empty", sb_q.size(), 0);
    endtask

    // Monitor: compares on every completed output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got Diff=%h, expected no output", Diff);
            end else begin
                mon_e = sb_q.pop_front();
                popped++;
                check("diff", Diff, mon_e.diff);
                check("bout", Bout, mon_e.bout);
                check("zero", Zero, mon_e.zero);
                check("neg",  Neg,  mon_e.neg);
                check("ovf",  Ovf,  mon_e.ovf);
                if (mon_e.chk_lat) check("latency", cyc - mon_e.acc, NG);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; X = '0; Y = '0; Bin = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", Diff, 0);
        check("rst_flags", {Bout, Zero, Neg, Ovf}, 0);
        check("rst_in_ready", in_ready, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_at_release", in_ready, 0);
        step();
        check("in_ready_after_release", in_ready, 1);

        // Directed single vectors: X, Y, Bin -> Diff, Bout, Zero, Neg, Ovf
        send(16'hD5D5, 16'h5555, 1'b0, 16'h8080, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1);
        drain();
        send(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1);
        send(16'h0000, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1);
        drain();
        send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1);
        send(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1);
        drain();
        send(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);
        drain();

        // Back-to-back stream with a 3-cycle output stall before the sixth vector
        send(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
        send(16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1);
        send(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
        send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1);
        out_ready = 1'b0;
        @(negedge clk);
        held_d = Diff;
        check("stall_held_value", held_d, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_diff_frozen", Diff, held_d);
        end
        step();
        out_ready = 1'b1;
        send(16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
        send(16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1);
        send(16'hABCD, 16'h1111, 1'b0, 16'h9ABC, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1);
        drain();

        // Reset with three vectors in flight: none of them may emerge
        send(16'h1111, 16'h0001, 1'b0, 16'h1110, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        send(16'h2222, 16'h0002, 1'b0, 16'h2220, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        send(16'h3333, 16'h0003, 1'b0, 16'h3330, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        step();
        check("pre_rst_out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_diff", Diff, 0);
        repeat (2) step();
        rst = 1'b0;
        repeat (6) step();
        check("post_rst_in_ready", in_ready, 1);
        send(16'h4444, 16'h0044, 1'b0, 16'h4400, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);
        drain();

        check("results_in_order_count", popped, pushed);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
